store_monitor: RTL and testbench
================================

# store_monitor

Synthesizable store-bus monitor downstream of the single-cycle CPU `top`. It consumes the data-memory write port (`DataAdr`, `WriteData`, `MemWrite`) and has two jobs. It decides the program's pass/fail outcome in hardware using the same rule the bench applies. It also buffers every observed store in a small FIFO, drained over a valid/ready handshake by a host or UART stage. This lets FPGA runs report results without a simulator.

## Interface
Parameters:
- `DEPTH`, 8: trace FIFO entries; power of two, minimum 2.
- `PASS_ADR`, 32'd100: address of the terminating store.
- `PASS_DATA`, 32'd7: data value that signals success.
- `SCRATCH_ADR`, 32'd96: only non-terminating store address that is tolerated.
- `TIMEOUT_CYCLES`, 1000: cycle budget; used only with `STORE_MONITOR_TIMEOUT_EN`.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `MemWrite`  in  1  store strobe from the CPU.
- `DataAdr`  in  32  store address.
- `WriteData`  in  32  store data.
- `trace_valid`  out  1  FIFO head holds an entry.
- `trace_ready`  in  1  consumer accepts the head entry.
- `trace_adr`  out  32  head entry address.
- `trace_data`  out  32  head entry data.
- `trace_count`  out  $clog2(DEPTH+1)  FIFO fill level, 0..DEPTH.
- `done`  out  1  FSM has left RUN.
- `pass`  out  1  FSM is in PASS.
- `overflow`  out  1  sticky flag: a store was dropped because the FIFO was full.
- `timeout`  out  1  sticky flag: the cycle budget expired.

## Operation
- FSM states: RUN (entered on reset), PASS, FAIL.
  - PASS and FAIL are terminal; only `reset` exits them.
- Store event: `MemWrite`=1, sampled on a rising edge while the FSM is in RUN.
- Transitions from RUN on a store event:
  - `DataAdr`==`PASS_ADR` and `WriteData`==`PASS_DATA` -> PASS.
  - Otherwise, `DataAdr`!=`SCRATCH_ADR` -> FAIL. This includes `PASS_ADR` written with any other data.
  - Otherwise (store to `SCRATCH_ADR`) -> stay in RUN.
- Trace push:
  - Every store event pushes {`DataAdr`, `WriteData`}, including the terminating store.
  - Stores seen in PASS or FAIL are neither pushed nor evaluated.
- Trace pop: occurs when `trace_valid` && `trace_ready` on a rising edge.
- Full FIFO:
  - A push without a simultaneous pop is dropped, `overflow` sets, and FSM evaluation still occurs.
  - A push with a simultaneous pop is accepted; the count is unchanged.
- Empty FIFO: `trace_valid`=0. `trace_adr`/`trace_data` are don't-care but stable.
- Pointers are log2(DEPTH) bits and wrap naturally. The count is tracked separately so that full and empty are distinguished.
- `trace_ready` asserted while the FIFO is empty has no effect.
- All outputs are driven from registers or FIFO storage. There is no combinational path from `MemWrite`, `DataAdr` or `WriteData` to any output.

## Timing
- Reset values: FSM=RUN, FIFO empty, `trace_valid`=0, `trace_count`=0, `done`=0, `pass`=0, `overflow`=0, `timeout`=0, timeout counter=0.
- Store at edge N:
  - `done`/`pass` reflect the decision after edge N, i.e. during cycle N+1.
  - If the FIFO was empty, `trace_valid`=1 and the entry is presented after edge N (one-cycle latency).
- Pop at edge N: the next entry, if any, is presented after edge N. This gives one entry per cycle sustained throughput.
- Handshake rule: while `trace_valid`=1 and no pop occurs, `trace_adr`/`trace_data` hold constant.
- Reset asserted mid-transfer discards all FIFO contents immediately, independent of `clk`.
- The CPU drives the store at most once per cycle. Back-to-back stores on consecutive edges are each a separate event.

## Configuration
- Macro: `STORE_MONITOR_TIMEOUT_EN`.
- Defined:
  - A cycle counter increments every cycle in RUN.
  - When it reaches `TIMEOUT_CYCLES` with no store event on that edge, the FSM goes to FAIL and `timeout` sets.
  - A terminating store on the same edge takes priority over the timeout.
  - The counter freezes outside RUN.
- Undefined: no counter is built, `timeout` is tied to 0, and RUN persists until a store event.

## Test plan
- Reset, then stores (96, 3), (96, 5), (100, 7) on consecutive cycles -> `done`=1 and `pass`=1 one cycle after the third store. FIFO holds 3 entries, drained in order.
- Store (100, 8) -> FAIL: `done`=1, `pass`=0. A subsequent store (100, 7) is ignored and not traced.
- Store (64, 7) -> FAIL. The FIFO holds that single entry, presented with `trace_valid`=1 one cycle later.
- Hold `trace_ready`=0 while making 10 stores to address 96 with DEPTH=8 -> `trace_count`=8, `overflow`=1, and the first 8 entries are preserved. Then, with the FIFO full, a store plus a pop on the same edge -> count stays 8 and the new entry is accepted.
- Hold `trace_ready`=1 during 5 back-to-back stores -> each entry is visible for exactly one cycle, and `trace_count` stays at most 1.
- With `STORE_MONITOR_TIMEOUT_EN` defined and `TIMEOUT_CYCLES`=20, make no stores -> FAIL and `timeout`=1 after 20 cycles. Assert `reset` mid-run -> all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/store_monitor.sv
// store_monitor
//   Watches the CPU data-memory write port. It decides the program's pass/fail
//   outcome in hardware and buffers every observed store in a small trace FIFO.
//   A host or UART stage drains the FIFO over a valid/ready handshake.
//
//   Optional feature macro: STORE_MONITOR_TIMEOUT_EN
//     When defined, a cycle budget is enforced while in RUN.
//     When undefined, timeout is tied to 0.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-high; clears all state
//   MemWrite     in   store strobe
//   DataAdr      in   [31:0] store address
//   WriteData    in   [31:0] store data
//   trace_valid  out  FIFO head holds an entry
//   trace_ready  in   consumer accepts the head entry
//   trace_adr    out  [31:0] head entry address
//   trace_data   out  [31:0] head entry data
//   trace_count  out  FIFO fill level, 0..DEPTH
//   done         out  FSM has left RUN
//   pass         out  FSM is in PASS
//   overflow     out  sticky: a store was dropped on a full FIFO
//   timeout      out  sticky: the cycle budget expired
//   o_dbg_state  out  [1:0] current FSM state (0 RUN, 1 PASS, 2 FAIL)
//
// Handshake: an entry transfers on a rising edge where trace_valid and
// trace_ready are both 1. While trace_valid=1 and no transfer happens,
// trace_adr/trace_data hold. trace_ready is ignored while the FIFO is empty.
module store_monitor #(
  parameter int          DEPTH          = 8,
  parameter logic [31:0] PASS_ADR       = 32'd100,
  parameter logic [31:0] PASS_DATA      = 32'd7,
  parameter logic [31:0] SCRATCH_ADR    = 32'd96,
  parameter int          TIMEOUT_CYCLES = 1000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         MemWrite,
  input  logic [31:0]                  DataAdr,
  input  logic [31:0]                  WriteData,
  output logic                         trace_valid,
  input  logic                         trace_ready,
  output logic [31:0]                  trace_adr,
  output logic [31:0]                  trace_data,
  output logic [$clog2(DEPTH+1)-1:0]   trace_count,
  output logic                         done,
  output logic                         pass,
  output logic                         overflow,
  output logic                         timeout,
  output logic [1:0]                   o_dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            w_timeout_set;

  logic [31:0]     r_mem_adr  [DEPTH];
  logic [31:0]     r_mem_data [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_overflow;
  logic            r_timeout;

  logic            w_store;
  logic            w_full;
  logic            w_pop;
  logic            w_push_ok;
  logic            w_drop;

  // Stores are only observed while the outcome is still undecided.
  assign w_store   = MemWrite && (r_state == ST_RUN);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_pop     = (r_count != '0) && trace_ready;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign w_push_ok = w_store && (!w_full || w_pop);
  assign w_drop    = w_store && w_full && !w_pop;

`ifdef STORE_MONITOR_TIMEOUT_EN
  logic [31:0] r_cycle_cnt;
  logic [31:0] w_cycle_next;

  assign w_cycle_next = r_cycle_cnt + 32'd1;

  // Counts edges spent in RUN; frozen once a verdict is reached.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cycle_cnt <= '0;
    end else if (r_state == ST_RUN) begin
      r_cycle_cnt <= w_cycle_next;
    end
  end
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = ^(32'(TIMEOUT_CYCLES));
`endif

  // Verdict logic. A store event on an edge always wins over the budget.
  always_comb begin
    w_state_next  = r_state;
    w_timeout_set = 1'b0;
    if (r_state == ST_RUN) begin
      if (MemWrite) begin
        if ((DataAdr == PASS_ADR) && (WriteData == PASS_DATA)) begin
          w_state_next = ST_PASS;
        end else if (DataAdr != SCRATCH_ADR) begin
          w_state_next = ST_FAIL;
        end
      end
`ifdef STORE_MONITOR_TIMEOUT_EN
      else if (w_cycle_next >= 32'(TIMEOUT_CYCLES)) begin
        w_state_next  = ST_FAIL;
        w_timeout_set = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      if (w_drop)        r_overflow <= 1'b1;
      if (w_timeout_set) r_timeout  <= 1'b1;
    end
  end

  // Storage needs no reset: the count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem_adr[r_wr_ptr]  <= DataAdr;
      r_mem_data[r_wr_ptr] <= WriteData;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign trace_valid = (r_count != '0);
  assign trace_adr   = r_mem_adr[r_rd_ptr];
  assign trace_data  = r_mem_data[r_rd_ptr];
  assign trace_count = r_count;
  assign done        = (r_state != ST_RUN);
  assign pass        = (r_state == ST_PASS);
  assign overflow    = r_overflow;
  assign timeout     = r_timeout;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_store_monitor.sv
module tb_store_monitor;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk;
  logic          reset;
  logic          MemWrite;
  logic [31:0]   DataAdr;
  logic [31:0]   WriteData;
  logic          trace_valid;
  logic          trace_ready;
  logic [31:0]   trace_adr;
  logic [31:0]   trace_data;
  logic [CW-1:0] trace_count;
  logic          done;
  logic          pass;
  logic          overflow;
  logic          timeout;
  logic [1:0]    dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_q[$];

  store_monitor #(
    .DEPTH          (DEPTH),
    .PASS_ADR       (32'd100),
    .PASS_DATA      (32'd7),
    .SCRATCH_ADR    (32'd96),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .MemWrite    (MemWrite),
    .DataAdr     (DataAdr),
    .WriteData   (WriteData),
    .trace_valid (trace_valid),
    .trace_ready (trace_ready),
    .trace_adr   (trace_adr),
    .trace_data  (trace_data),
    .trace_count (trace_count),
    .done        (done),
    .pass        (pass),
    .overflow    (overflow),
    .timeout     (timeout),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples mid-cycle; a visible valid&&ready means the head
  // entry transfers on the coming rising edge.
  always @(negedge clk) begin
    if (!reset && trace_valid && trace_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL trace_unexpected: got %0h_%0h expected nothing", trace_adr, trace_data);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("trace_entry", {trace_adr, trace_data}, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    MemWrite    = 1'b0;
    DataAdr     = '0;
    WriteData   = '0;
    trace_ready = 1'b0;
    reset       = 1'b1;
    exp_q.delete();
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Drives one store for exactly one rising edge; returns at edge+1.
  task automatic store(input logic [31:0] adr, input logic [31:0] data, input bit traced);
    MemWrite  = 1'b1;
    DataAdr   = adr;
    WriteData = data;
    if (traced) exp_q.push_back({adr, data});
    tick();
    MemWrite = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    do_reset();
    check("rst_done",     done,        0);
    check("rst_pass",     pass,        0);
    check("rst_valid",    trace_valid, 0);
    check("rst_count",    trace_count, 0);
    check("rst_overflow", overflow,    0);
    check("rst_timeout",  timeout,     0);
    check("rst_state",    dbg_state,   0);

    // Passing program: two scratch stores then the terminating store.
    store(32'd96, 32'd3, 1);
    store(32'd96, 32'd5, 1);
    check("scratch_done", done, 0);
    store(32'd100, 32'd7, 1);
    check("pass_done",  done,        1);
    check("pass_pass",  pass,        1);
    check("pass_count", trace_count, 3);
    trace_ready = 1'b1;
    repeat (4) tick();
    trace_ready = 1'b0;
    check("pass_drained", trace_count, 0);

    // Terminating address with wrong data fails; later stores ignored.
    do_reset();
    store(32'd100, 32'd8, 1);
    check("baddata_done", done, 1);
    check("baddata_pass", pass, 0);
    store(32'd100, 32'd7, 0);
    check("ignored_pass",  pass,        0);
    check("ignored_count", trace_count, 1);
    trace_ready = 1'b1;
    repeat (2) tick();
    trace_ready = 1'b0;

    // Foreign address fails; single entry visible one cycle later.
    do_reset();
    store(32'd64, 32'd7, 1);
    check("foreign_done",  done,        1);
    check("foreign_pass",  pass,        0);
    check("foreign_valid", trace_valid, 1);
    check("foreign_count", trace_count, 1);
    check("foreign_head",  {trace_adr, trace_data}, {32'd64, 32'd7});
    trace_ready = 1'b1;
    repeat (2) tick();
    trace_ready = 1'b0;

    // Overflow: 10 stores with no consumer, only the first 8 kept.
    do_reset();
    for (int i = 0; i < 10; i++) store(32'd96, 32'(i), (i < DEPTH));
    check("ovf_count",    trace_count, DEPTH);
    check("ovf_flag",     overflow,    1);
    check("ovf_done",     done,        0);
    check("ovf_head",     {trace_adr, trace_data}, {32'd96, 32'd0});
    // Full FIFO: push plus pop on the same edge is accepted.
    trace_ready = 1'b1;
    store(32'd96, 32'd100, 1);
    check("full_pushpop_count", trace_count, DEPTH);
    repeat (10) tick();
    check("full_drained", trace_count, 0);
    trace_ready = 1'b0;
    // Asynchronous reset between edges with data in flight.
    store(32'd96, 32'd55, 1);
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("async_count",    trace_count, 0);
    check("async_valid",    trace_valid, 0);
    check("async_overflow", overflow,    0);
    check("async_done",     done,        0);

    // Streaming: consumer always ready, at most one entry buffered.
    do_reset();
    trace_ready = 1'b1;
    tick();
    check("empty_ready_count", trace_count, 0);
    check("empty_ready_valid", trace_valid, 0);
    for (int i = 0; i < 5; i++) begin
      store(32'd96, 32'h10 + 32'(i), 1);
      check("stream_count_le1", (trace_count <= 1), 1);
      check("stream_valid",     trace_valid,        1);
    end
    repeat (2) tick();
    check("stream_drained", trace_count, 0);
    trace_ready = 1'b0;

    // Cycle budget.
    do_reset();
`ifdef STORE_MONITOR_TIMEOUT_EN
    repeat (19) tick();
    check("to_before_done", done,    0);
    check("to_before_flag", timeout, 0);
    tick();
    check("to_done",  done,      1);
    check("to_pass",  pass,      0);
    check("to_flag",  timeout,   1);
    check("to_state", dbg_state, 2);
`else
    repeat (30) tick();
    check("no_to_done", done,    0);
    check("no_to_flag", timeout, 0);
`endif

    check("leftover_expected", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
